// File: rtl/int_to_float.sv
// int_to_float: serial 16-bit integer to IEEE-754 half-precision encoder.
// The magnitude is left-normalised one bit per clock, then packed with
// truncation; any nonzero discarded bits raise precisionLost.
module int_to_float #(
  parameter bit SIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] in_int,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        zero,
  output logic        precisionLost
);

  typedef enum logic [1:0] {StIdle, StNorm, StDone} state_e;

  localparam logic [4:0] ExpStart = 5'd30;

  state_e      r_state;
  logic        r_sign;
  logic [15:0] r_mag;
  logic [4:0]  r_exp;
  logic        r_busy;
  logic        r_done;
  logic [15:0] r_result;
  logic        r_zero;
  logic        r_lost;

  logic        w_sign;
  logic [15:0] w_mag;

  // Operand capture: -32768 negates to 16'h8000, which fits unsigned.
  always_comb begin
    w_sign = SIGNED & in_int[15];
    w_mag  = w_sign ? (~in_int + 16'd1) : in_int;
  end

  // Control FSM with registered status and result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= StIdle;
      r_sign   <= 1'b0;
      r_mag    <= 16'h0000;
      r_exp    <= 5'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= 16'h0000;
      r_zero   <= 1'b0;
      r_lost   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          r_done <= 1'b0;
          if (start) begin
            r_sign  <= w_sign;
            r_mag   <= w_mag;
            r_exp   <= ExpStart;
            r_busy  <= 1'b1;
            r_state <= StNorm;
          end else begin
            r_state <= StIdle;
          end
        end
        StNorm: begin
          if (r_mag == 16'h0000) begin
            // Zero input always packs as +0.
            r_result <= 16'h0000;
            r_zero   <= 1'b1;
            r_lost   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= StDone;
          end else if (r_mag[15]) begin
            // Hidden bit is mag[15]; the fraction is truncated.
            r_result <= {r_sign, r_exp, r_mag[14:5]};
            r_zero   <= 1'b0;
            r_lost   <= |r_mag[4:0];
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= StDone;
          end else begin
            r_mag <= {r_mag[14:0], 1'b0};
            r_exp <= r_exp - 5'd1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign result        = r_result;
  assign zero          = r_zero;
  assign precisionLost = r_lost;

endmodule
